uart_rx_ctrl: RTL and testbench

Bus-slave controller that sits between the UART receive datapath and the CPU bus. Captures each received byte (one-cycle rx_end strobe plus rx_data) into a FIFO and reports status and overrun. Raises a level interrupt on a programmable fill threshold. The CPU drains the FIFO through a small register map with a one-cycle registered read.

---
 rtl/uart_rx_ctrl.sv | 81 ++++++++
 tb/tb_uart_rx_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-byte FIFO with overrun, fill-threshold irq and a CPU register map
// Reads and writes complete with a one-cycle registered ack.
module uart_rx_ctrl #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_end,
    input  logic [7:0]        rx_data,
    input  logic              rx_busy,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ack,
    output logic              irq
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(1 << DEPTH_LOG2);

    logic [7:0] mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n, thresh, thresh_n, wr_thresh;
    logic overrun, overrun_n, irq_en, irq_en_n;
    logic rd, wr, pop, push, flush, full;
    logic [DATA_W-1:0] status, rd_val;
    logic unused;

    assign unused = ^wr_data;

    always_comb begin
        rd = req & ~we;
        wr = req & we;
        full = count == FULL;
        pop = rd & (addr == 2'd1) & (count != '0);
        flush = wr & (addr == 2'd2) & wr_data[1];
        // a pop in the same cycle frees the slot a full push needs
        push = rx_end & ~flush & (~full | pop);
        overrun_n = (rx_end & ~flush & full & ~pop) | (overrun & ~(wr & (addr == 2'd0) & wr_data[1]));
        count_n = flush ? '0 : count + CW'(push) - CW'(pop);
        wr_thresh = (wr_data[CW-1:0] == '0) ? CW'(1) : (wr_data[CW-1:0] > FULL) ? FULL : wr_data[CW-1:0];
        thresh_n = (wr & (addr == 2'd3)) ? wr_thresh : thresh;
        irq_en_n = (wr & (addr == 2'd2)) ? wr_data[0] : irq_en;
        status = '0;
        status[3:0] = {full, rx_busy, overrun, count != '0};
        status[4 +: CW] = count;
        rd_val = (addr == 2'd0) ? status :
                 (addr == 2'd1) ? (pop ? DATA_W'(mem[rd_ptr]) : '0) :
                 (addr == 2'd2) ? DATA_W'(irq_en) : DATA_W'(thresh);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overrun <= 1'b0;
            irq_en <= 1'b0;
            thresh <= CW'(1);
            rd_data <= '0;
            ack <= 1'b0;
            irq <= 1'b0;
        end else begin
            wr_ptr <= flush ? '0 : push ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
            rd_ptr <= flush ? '0 : pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
            count <= count_n;
            overrun <= overrun_n;
            irq_en <= irq_en_n;
            thresh <= thresh_n;
            ack <= req;
            irq <= irq_en_n & ((count_n >= thresh_n) | overrun_n);
            if (rd) rd_data <= rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random traffic against a queue-based model;
// a negedge monitor scores ack, rd_data and irq from a response queue.
module tb_uart_rx_ctrl;
    logic clk = 1'b0;
    logic reset, rx_end, rx_busy, req, we, ack, irq;
    logic [7:0] rx_data;
    logic [1:0] addr;
    logic [31:0] wr_data, rd_data;

    uart_rx_ctrl dut (
        .clk(clk), .reset(reset), .rx_end(rx_end), .rx_data(rx_data), .rx_busy(rx_busy),
        .req(req), .we(we), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .ack(ack), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {bit rd; logic [31:0] v;} resp_t;
    resp_t sb[$];
    resp_t got;
    logic [7:0] mq[$];
    bit m_ovr, m_en, exp_ack, exp_irq, armed;
    int m_th = 1;
    int checks = 0, errors = 0;

    task automatic cyc(input bit e, input logic [7:0] d, input bit r, input bit w,
                       input logic [1:0] a, input logic [31:0] wd, input bit busy = 1'b0);
        logic [31:0] v;
        bit pop, flush;
        rx_end = e; rx_data = d; req = r; we = w; addr = a; wr_data = wd; rx_busy = busy;
        case (a)
            2'd0: v = 32'(mq.size()) * 16 + (mq.size() == 8 ? 8 : 0) + (busy ? 4 : 0)
                      + (m_ovr ? 2 : 0) + (mq.size() != 0 ? 1 : 0);
            2'd1: v = mq.size() != 0 ? 32'(mq[0]) : 32'd0;
            2'd2: v = 32'(m_en);
            default: v = 32'(m_th);
        endcase
        if (r) sb.push_back('{!w, v});
        pop = r && !w && a == 2'd1 && mq.size() > 0;
        flush = r && w && a == 2'd2 && wd[1];
        if (pop) void'(mq.pop_front());
        if (r && w && a == 2'd0 && wd[1]) m_ovr = 1'b0;
        if (e && !flush) begin
            if (mq.size() < 8) mq.push_back(d);
            else m_ovr = 1'b1;
        end
        if (flush) mq.delete();
        if (r && w && a == 2'd2) m_en = wd[0];
        if (r && w && a == 2'd3) m_th = wd[3:0] == 0 ? 1 : wd[3:0] > 8 ? 8 : int'(wd[3:0]);
        @(posedge clk);
        exp_ack = r;
        exp_irq = m_en && (mq.size() >= m_th || m_ovr);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d); cyc(1'b1, d, 1'b0, 1'b0, 2'd0, 32'd0); endtask
    task automatic rd(input logic [1:0] a); cyc(1'b0, 8'd0, 1'b1, 1'b0, a, 32'd0); endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] v); cyc(1'b0, 8'd0, 1'b1, 1'b1, a, v); endtask

    // reset asserted together with a bus request and a byte: neither may survive
    task automatic do_reset();
        reset = 1'b1; rx_end = 1'b1; rx_data = 8'h5A; rx_busy = 1'b0;
        req = 1'b1; we = 1'b0; addr = 2'd1; wr_data = 32'd0;
        @(posedge clk);
        mq.delete(); m_ovr = 1'b0; m_en = 1'b0; m_th = 1; exp_ack = 1'b0; exp_irq = 1'b0;
        @(negedge clk);
        reset = 1'b0; rx_end = 1'b0; req = 1'b0;
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd_data got %h want 0", rd_data);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL ack got %b want %b at %0t", ack, exp_ack, $time);
            end
            if (ack === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected got ack with no request pending at %0t", $time);
                end else begin
                    got = sb.pop_front();
                    if (got.rd && rd_data !== got.v) begin
                        errors++;
                        $display("FAIL rd_data got %h want %h at %0t", rd_data, got.v, $time);
                    end
                end
            end
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL irq got %b want %b at %0t", irq, exp_irq, $time);
            end
        end
    end

    initial begin
        do_reset();
        armed = 1'b1;
        rd(2'd0);
        push(8'h41); push(8'h42); push(8'h43);
        rd(2'd1); rd(2'd1); rd(2'd1); rd(2'd0); rd(2'd1); rd(2'd0);
        for (int i = 0; i < 9; i++) push(8'(i));
        rd(2'd0);
        for (int i = 0; i < 8; i++) rd(2'd1);
        wr(2'd0, 32'h2); rd(2'd0);
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        cyc(1'b1, 8'hAA, 1'b1, 1'b0, 2'd1, 32'd0);
        rd(2'd0);
        for (int i = 0; i < 8; i++) rd(2'd1);
        rd(2'd0);
        wr(2'd2, 32'h1); wr(2'd3, 32'd3);
        push(8'h01); push(8'h02); push(8'h03); rd(2'd1);
        wr(2'd3, 32'd5);
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
        cyc(1'b1, 8'h55, 1'b1, 1'b1, 2'd2, 32'h3);
        rd(2'd0); rd(2'd3);
        wr(2'd3, 32'd0); rd(2'd3); wr(2'd3, 32'd12); rd(2'd3); rd(2'd2);
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                2'($urandom), $urandom, 1'($urandom));
        wr(2'd2, 32'h1); push(8'h77); rd(2'd0);
        do_reset();
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 32'd0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
